// File: rtl/wb_redirect_unit_if.sv
// Signal bundle between the decode/execute pipe registers, the load port and
// the writeback/redirect stage. "master" is the upstream side, "slave" is the stage.
interface wb_redirect_unit_if;
    logic        x_valid;
    logic [15:0] x_pc;
    logic [3:0]  x_rt;
    logic [15:0] x_result;
    logic [15:0] x_va;
    logic [15:0] x_vt;
    logic        x_isJmp;
    logic        x_isJz;
    logic        x_isJnz;
    logic        x_isJs;
    logic        x_isJns;
    logic        x_isLd;
    logic        x_isSt;
    logic        x_isHalt;
    logic        x_writesReg;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_ren;
    logic [15:0] mem_raddr;
    logic        wb_wen;
    logic [3:0]  wb_waddr;
    logic [15:0] wb_wdata;
    logic        x_stall;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        halted;

    modport master (
        output x_valid, x_pc, x_rt, x_result, x_va, x_vt,
        output x_isJmp, x_isJz, x_isJnz, x_isJs, x_isJns,
        output x_isLd, x_isSt, x_isHalt, x_writesReg,
        output mem_rdata, mem_rvalid,
        input  mem_ren, mem_raddr, wb_wen, wb_waddr, wb_wdata,
        input  x_stall, flush, redirect_pc, halted
    );

    modport slave (
        input  x_valid, x_pc, x_rt, x_result, x_va, x_vt,
        input  x_isJmp, x_isJz, x_isJnz, x_isJs, x_isJns,
        input  x_isLd, x_isSt, x_isHalt, x_writesReg,
        input  mem_rdata, mem_rvalid,
        output mem_ren, mem_raddr, wb_wen, wb_waddr, wb_wdata,
        output x_stall, flush, redirect_pc, halted
    );
endinterface

// File: rtl/wb_redirect_unit.sv
// Writeback / control-redirect stage: retires one instruction per cycle, resolves
// jumps into a timed flush plus redirect PC, sequences loads and latches halt.
module wb_redirect_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_redirect_unit_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_LD = 2'd1,
        HALTED  = 2'd2
    } state_e;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        mem_ren_q, mem_ren_d;
    logic [15:0] mem_raddr_q, mem_raddr_d;
    logic        wb_wen_q, wb_wen_d;
    logic [3:0]  wb_waddr_q, wb_waddr_d;
    logic [15:0] wb_wdata_q, wb_wdata_d;
    logic [15:0] redirect_pc_q, redirect_pc_d;
    logic        halted_q, halted_d;
    logic [3:0]  ld_rt_q, ld_rt_d;
    logic        accept_s;
    logic        is_jump_s;
    logic        unused_s;

    function automatic logic jump_taken(
        input logic        is_jmp,
        input logic        is_jz,
        input logic        is_jnz,
        input logic        is_js,
        input logic        is_jns,
        input logic [15:0] va
    );
        logic zero_v;
        zero_v = (va == 16'd0);
        return is_jmp | (is_jz & zero_v) | (is_jnz & ~zero_v) |
               (is_js & va[15]) | (is_jns & ~va[15]);
    endfunction

    // A valid instruction arriving during a flush window is squashed, not accepted.
    assign accept_s  = bus.x_valid & (state_q == RUN) & (flush_cnt_q == 3'd0);
    assign is_jump_s = bus.x_isJmp | bus.x_isJz | bus.x_isJnz | bus.x_isJs | bus.x_isJns;
    assign unused_s  = ^bus.x_pc;

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = (flush_cnt_q != 3'd0) ? (flush_cnt_q - 3'd1) : 3'd0;
        mem_ren_d     = 1'b0;
        mem_raddr_d   = mem_raddr_q;
        wb_wen_d      = 1'b0;
        wb_waddr_d    = wb_waddr_q;
        wb_wdata_d    = wb_wdata_q;
        redirect_pc_d = redirect_pc_q;
        halted_d      = halted_q;
        ld_rt_d       = ld_rt_q;
        case (state_q)
            RUN: begin
                if (!accept_s) begin
                    state_d = RUN;
                end else if (bus.x_isHalt) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                end else if (bus.x_isLd) begin
                    state_d     = WAIT_LD;
                    mem_ren_d   = 1'b1;
                    mem_raddr_d = bus.x_result;
                    ld_rt_d     = bus.x_rt;
                end else if (is_jump_s) begin
                    if (jump_taken(bus.x_isJmp, bus.x_isJz, bus.x_isJnz,
                                   bus.x_isJs, bus.x_isJns, bus.x_va)) begin
                        redirect_pc_d = bus.x_vt;
                        flush_cnt_d   = FLUSH_INIT;
                    end else begin
                        redirect_pc_d = redirect_pc_q;
                    end
                end else if (bus.x_writesReg && !bus.x_isSt && (bus.x_rt != 4'd0)) begin
                    wb_wen_d   = 1'b1;
                    wb_waddr_d = bus.x_rt;
                    wb_wdata_d = bus.x_result;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT_LD: begin
                if (!bus.mem_rvalid) begin
                    state_d = WAIT_LD;
                end else if (ld_rt_q != 4'd0) begin
                    state_d    = RUN;
                    wb_wen_d   = 1'b1;
                    wb_waddr_d = ld_rt_q;
                    wb_wdata_d = bus.mem_rdata;
                end else begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                state_d  = HALTED;
                halted_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            flush_cnt_q   <= 3'd0;
            mem_ren_q     <= 1'b0;
            mem_raddr_q   <= 16'd0;
            wb_wen_q      <= 1'b0;
            wb_waddr_q    <= 4'd0;
            wb_wdata_q    <= 16'd0;
            redirect_pc_q <= 16'd0;
            halted_q      <= 1'b0;
            ld_rt_q       <= 4'd0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_ren_q     <= mem_ren_d;
            mem_raddr_q   <= mem_raddr_d;
            wb_wen_q      <= wb_wen_d;
            wb_waddr_q    <= wb_waddr_d;
            wb_wdata_q    <= wb_wdata_d;
            redirect_pc_q <= redirect_pc_d;
            halted_q      <= halted_d;
            ld_rt_q       <= ld_rt_d;
        end
    end

    assign bus.mem_ren     = mem_ren_q;
    assign bus.mem_raddr   = mem_raddr_q;
    assign bus.wb_wen      = wb_wen_q;
    assign bus.wb_waddr    = wb_waddr_q;
    assign bus.wb_wdata    = wb_wdata_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.halted      = halted_q;
    assign bus.x_stall     = (state_q != RUN);
    assign bus.flush       = (flush_cnt_q != 3'd0);
endmodule
